// File: rtl/unary_stream_decoder.sv
// Unary stream decoder: counts a burst of consecutive ones after an arm handshake and
// returns the binary count on a valid/ready port; no burst within Timeout cycles yields 0.
module unary_stream_decoder #(
  parameter int unsigned BinBits = 4,
  parameter int unsigned OutBits = 2 * BinBits + 1,
  parameter int unsigned Timeout = 1 << (2 * BinBits)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  output logic               start_ready_o,
  input  logic               in_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [OutBits-1:0] out_value_o,
  output logic               out_sat_o,
  output logic               busy_o
);

  localparam int unsigned TimerW = $clog2(Timeout) + 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(Timeout - 1);
  localparam logic [OutBits-1:0] CountMax = '1;

  typedef enum logic [1:0] {StIdle, StWait, StCount, StDone} state_e;

  state_e              state_q, state_d;
  logic [OutBits-1:0]  count_q, count_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                sat_q, sat_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      count_q <= '0;
      timer_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StWait;
          count_d = '0;
          timer_d = '0;
          sat_d   = 1'b0;
        end
      end
      StWait: begin
        if (in_i) begin
          count_d = OutBits'(1);
          state_d = StCount;
        end else if (timer_q == TimerMax) begin
          count_d = '0;
          state_d = StDone;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StCount: begin
        if (in_i) begin
          // Hold at the maximum and flag that at least one increment was dropped.
          if (count_q == CountMax) begin
            sat_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign start_ready_o = (state_q == StIdle);
  assign out_valid_o   = (state_q == StDone);
  assign busy_o        = (state_q == StWait) || (state_q == StCount);
  assign out_value_o   = count_q;
  assign out_sat_o     = sat_q;

endmodule
